// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of mem_port_arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [3:0]            m0_wstrb;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  grant;
    logic                  busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_rdata, m0_ack,
        input  m1_req, m1_addr,
        output m1_rdata, m1_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output grant, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_rdata, m0_ack,
        output m1_req, m1_addr,
        input  m1_rdata, m1_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between m0 (data r/w) and m1 (fetch).
// Fixed m0 priority; define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  txn_we_q, txn_we_d;
    logic                  mem_en_q, mem_en_d;
    logic [3:0]            mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;
    logic                  pick_m1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_grant_q, last_grant_d;

    // On contention the port opposite to the previous owner wins.
    assign pick_m1 = bus.m1_req && (!bus.m0_req || !last_grant_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == DONE) last_grant_d = grant_q;
    end
`else
    assign pick_m1 = bus.m1_req && !bus.m0_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            txn_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            txn_we_q    <= txn_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        txn_we_d    = txn_we_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_ack_d    = m0_ack_q;
        m1_ack_d    = m1_ack_q;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d  = ACCESS;
                    grant_d  = pick_m1;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    if (pick_m1) begin
                        mem_addr_d = bus.m1_addr;
                        mem_we_d   = '0;
                        txn_we_d   = 1'b0;
                    end else begin
                        mem_addr_d  = bus.m0_addr;
                        mem_wdata_d = bus.m0_wdata;
                        mem_we_d    = bus.m0_we ? bus.m0_wstrb : 4'b0000;
                        txn_we_d    = bus.m0_we;
                    end
                end
            end
            ACCESS: begin
                state_d  = RESP;
                mem_en_d = 1'b0;
                mem_we_d = '0;
            end
            RESP: begin
                // txn_we_q, not mem_we_q: a zero-strobe write must still leave m0_rdata alone.
                state_d = DONE;
                if (grant_q) begin
                    m1_rdata_d = bus.mem_rdata;
                    m1_ack_d   = 1'b1;
                end else begin
                    if (!txn_we_q) m0_rdata_d = bus.mem_rdata;
                    m0_ack_d = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                m0_ack_d = 1'b0;
                m1_ack_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc;
    int          n_tests;
    int          n_fail;
    bit          last_g;
    logic [31:0] exp_r0, exp_r1;
    int          ack_cyc;

    logic [31:0] ram [int unsigned];
    logic [31:0] mdl [int unsigned];

    function automatic logic [31:0] ram_init(logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous single-port memory: data appears the cycle after mem_en.
    always @(posedge clk) begin
        logic [31:0] cur;
        if (bus.mem_en) begin
            cur = ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : ram_init(bus.mem_addr);
            bus.mem_rdata <= cur;
            ram[bus.mem_addr] = merge(cur, bus.mem_wdata, bus.mem_we);
        end
    end

    function automatic logic [31:0] mread(logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : ram_init(a);
    endfunction

    function automatic bit pick(bit r0, bit r1, bit last);
        if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Runs one full transaction starting from IDLE with the current requests applied.
    task automatic serve_one(input bit keep0, input bit drop_early, output bit w);
        bit          wr;
        logic [31:0] a, wd, rd;
        logic [3:0]  we_exp;
        w      = pick(bus.m0_req, bus.m1_req, last_g);
        a      = w ? bus.m1_addr : bus.m0_addr;
        wr     = !w && bus.m0_we;
        we_exp = wr ? bus.m0_wstrb : 4'b0000;
        wd     = bus.m0_wdata;
        rd     = mread(a);
        if (wr) mdl[a] = merge(rd, wd, we_exp);

        step();
        chk("access_en",    32'(bus.mem_en), 32'd1);
        chk("access_we",    32'(bus.mem_we), 32'(we_exp));
        chk("access_addr",  bus.mem_addr, a);
        chk("access_grant", 32'(bus.grant), 32'(w));
        chk("access_busy",  32'(bus.busy), 32'd1);
        if (!w) chk("access_wdata", bus.mem_wdata, wd);
        if (drop_early) begin
            if (w) bus.m1_req = 1'b0;
            else   bus.m0_req = 1'b0;
        end

        step();
        chk("resp_en",   32'(bus.mem_en), 32'd0);
        chk("resp_we",   32'(bus.mem_we), 32'd0);
        chk("resp_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);

        step();
        if (!wr) begin
            if (w) exp_r1 = rd;
            else   exp_r0 = rd;
        end
        chk("done_acks",   32'({bus.m1_ack, bus.m0_ack}), w ? 32'd2 : 32'd1);
        chk("done_rdata0", bus.m0_rdata, exp_r0);
        chk("done_rdata1", bus.m1_rdata, exp_r1);
        chk("done_grant",  32'(bus.grant), 32'(w));
        ack_cyc = cyc;
        if (w)          bus.m1_req = 1'b0;
        else if (!keep0) bus.m0_req = 1'b0;

        step();
        chk("idle_acks", 32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_en",   32'(bus.mem_en), 32'd0);
        chk("idle_addr", bus.mem_addr, a);
        last_g = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        bit g [3];
        int ack_t [3];
        bit exp_g [3];
        n_tests = 0; n_fail = 0; cyc = 0;
        last_g = 1'b1; exp_r0 = '0; exp_r1 = '0;
        reset = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0;
        ram[32'h10]   = 32'h0000_0013; mdl[32'h10]   = 32'h0000_0013;
        ram[32'h1004] = 32'h1122_3344; mdl[32'h1004] = 32'h1122_3344;
        ram[32'h1008] = 32'hCAFE_F00D; mdl[32'h1008] = 32'hCAFE_F00D;

        step();
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_en",    32'(bus.mem_en), 32'd0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'd0);
        chk("rst_acks",  32'({bus.m1_ack, bus.m0_ack}), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_rd0",   bus.m0_rdata, 32'd0);
        reset = 1'b0;

        // Fetch right after reset release
        bus.m1_req = 1'b1; bus.m1_addr = 32'h10;
        serve_one(1'b0, 1'b0, w);
        chk("fetch_grant", 32'(w), 32'd1);
        chk("fetch_data",  bus.m1_rdata, 32'h0000_0013);

        // Partial-strobe write then read-back
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h1004;
        bus.m0_wdata = 32'hAABB_CCDD; bus.m0_wstrb = 4'b0011;
        serve_one(1'b0, 1'b0, w);
        chk("wr_rdata_kept", bus.m0_rdata, 32'd0);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0;
        serve_one(1'b0, 1'b0, w);
        chk("rd_1004", bus.m0_rdata, 32'h1122_CCDD);

        // Zero-strobe write leaves memory unchanged
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h1008;
        bus.m0_wdata = 32'h1234_5678; bus.m0_wstrb = 4'b0000;
        serve_one(1'b0, 1'b0, w);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0;
        serve_one(1'b0, 1'b0, w);
        chk("rd_1008", bus.m0_rdata, 32'hCAFE_F00D);

        // Request withdrawn before ack still completes
        bus.m1_req = 1'b1; bus.m1_addr = 32'h1004;
        serve_one(1'b0, 1'b1, w);

        // Reset during RESP of a fetch
        bus.m1_req = 1'b1; bus.m1_addr = 32'h10;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_busy",  32'(bus.busy), 32'd0);
        chk("midrst_ack",   32'(bus.m1_ack), 32'd0);
        chk("midrst_en",    32'(bus.mem_en), 32'd0);
        chk("midrst_grant", 32'(bus.grant), 32'd0);
        chk("midrst_rd1",   bus.m1_rdata, 32'd0);
        bus.m1_req = 1'b0;
        exp_r0 = '0; exp_r1 = '0; last_g = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_noack", 32'({bus.m1_ack, bus.m0_ack, bus.busy}), 32'd0);
        end

        // Contention with m0 continuously requesting
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
`endif
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1004;
        bus.m1_req = 1'b1; bus.m1_addr = 32'h10;
        for (int i = 0; i < 3; i++) begin
            serve_one(1'b1, 1'b0, g[i]);
            ack_t[i] = ack_cyc;
            chk("contend_grant", 32'(g[i]), 32'(exp_g[i]));
        end
        chk("contend_gap01", 32'(ack_t[1] - ack_t[0]), 32'd4);
        chk("contend_gap12", 32'(ack_t[2] - ack_t[1]), 32'd4);
        bus.m0_req = 1'b0;
        if (bus.m1_req) begin
            serve_one(1'b0, 1'b0, w);
            chk("contend_m1_last", 32'(w), 32'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!bus.m0_req && $urandom_range(0, 1) == 1) begin
                bus.m0_req   = 1'b1;
                bus.m0_we    = 1'($urandom_range(0, 1));
                bus.m0_addr  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
                bus.m0_wdata = $urandom;
                bus.m0_wstrb = 4'($urandom_range(0, 15));
            end
            if (!bus.m1_req && (!bus.m0_req || $urandom_range(0, 1) == 1)) begin
                bus.m1_req  = 1'b1;
                bus.m1_addr = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            end
            serve_one(1'b0, 1'b0, w);
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.m0_req || bus.m1_req) serve_one(1'b0, 1'b0, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous block RAM between the data-access port (m0, read/write) and the instruction-fetch port (m1, read-only).
- Sits between the core's fetch/load-store paths and the unified memory array.
- Serialises requests through a fixed 4-state sequence with registered, single-cycle acknowledge.
- Fixed priority by default; optional round-robin.

Parameters:
ADDR_WIDTH, 32, width of requester and memory addresses
DATA_WIDTH, 32, word width; must be 32 (wstrb is 4 bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  data port request; held high until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_WIDTH  data word address
m0_wdata  in  DATA_WIDTH  write data
m0_wstrb  in  4  byte enables for writes
m0_rdata  out  DATA_WIDTH  read data, valid while m0_ack=1
m0_ack  out  1  one-cycle completion pulse
m1_req  in  1  fetch request; held high until m1_ack
m1_addr  in  ADDR_WIDTH  instruction word address
m1_rdata  out  DATA_WIDTH  fetched word, valid while m1_ack=1
m1_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access enable
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_WIDTH  memory word address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en
grant  out  1  owner of current transaction: 0 = m0, 1 = m1
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACCESS, RESP, DONE. All outputs registered.
- Reset values: state = IDLE; every output = 0; internal last_grant = 1.
- IDLE: if any req is high, choose a winner and set grant.
  - Latch winner's addr into mem_addr.
  - For m0 only, latch wdata into mem_wdata.
  - mem_we <= (m0 winner && m0_we) ? m0_wstrb : 4'b0.
  - mem_en <= 1. Go to ACCESS.
  - Requester inputs are sampled only on this edge.
- ACCESS: mem_en = 1 for exactly this cycle. Next edge: mem_en <= 0, mem_we <= 0, go to RESP.
- RESP: mem_rdata is valid.
  - Read: capture mem_rdata into the winner's rdata register.
  - Write: leave m0_rdata unchanged.
  - Set the winner's ack <= 1. Go to DONE.
- DONE: winner's ack = 1 for this single cycle; no arbitration in this cycle, so the req still high during ack is ignored. Next edge: ack <= 0, update last_grant, go to IDLE.
- Latency: req seen high in IDLE cycle N → mem_en in N+1 → ack in N+3. Throughput is one transaction per 4 cycles.
- m0_rdata and m1_rdata hold their last value until overwritten by a later read for that port.
- Arbitration (default): m0 wins on simultaneous requests.
- m0 write with m0_wstrb = 0: full handshake, mem_en pulses, mem_we = 0, memory unchanged, ack still pulses.
- Req dropped before ack (protocol violation): the transaction completes and ack still pulses.
- mem_addr and mem_wdata hold their values after the transaction; only mem_en and mem_we return to 0.
- Reset asserted mid-transaction: immediately go to IDLE with all outputs at 0. A pending write whose ACCESS cycle had not yet occurred is dropped.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the port opposite to last_grant. The first contention after reset goes to m0 (last_grant resets to 1).
- Undefined: fixed priority, m0 always wins; last_grant is unused and may be optimised away.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset release, m1_req=1, m1_addr=0x10, RAM[0x10]=0x00000013 → mem_en high exactly one cycle (N+1), m1_ack pulse at N+3, m1_rdata=0x00000013, grant=1.
- m0 write: addr=0x1004, wdata=0xAABBCCDD, wstrb=4'b0011 over RAM 0x11223344 → mem_we=4'b0011 during ACCESS; m0 read of 0x1004 then returns 0x1122CCDD; m0_rdata unchanged after the write ack.
- m0_req and m1_req high together for 3 transactions, default build → grants m0, m0, m0 while m0 keeps requesting; m1 served only after m0 drops.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN → grants m0, m1, m0; each ack 4 cycles apart.
- Reset asserted during RESP of an m1 read → next cycle: state IDLE, busy=0, m1_ack=0, mem_en=0, no ack ever issued.
- m0 write with wstrb=4'b0000 to 0x1008 → ack pulse after 3 cycles, mem_we=0 throughout, RAM[0x1008] unchanged.
